fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl.sv | 112 +++++++++++
 tb/tb_fetch_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch address, runs the request/ack handshake with
// instruction memory, delivers words to IF/ID and tracks redirects that land mid-fetch.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stop_all,
  input  logic        is_branch_input,
  input  logic [31:0] branch_address_input,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_data,
  output logic        ibus_request,
  output logic [31:0] ibus_address,
  output logic [31:0] program_counter,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic        stall_request,
  output logic        bus_error
);

  typedef enum logic [1:0] {StReset, StReq, StHold, StErr} state_e;

  localparam logic [7:0] CountLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        bus_error_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic [7:0]  count_q;

  logic        stop_fetch;
  logic        branch_take;
  logic [31:0] pc_inc;
  logic        unused_stop_bits;

  assign stop_fetch       = stop_all[0];
  assign branch_take      = !stop_fetch && is_branch_input;
  assign pc_inc           = pc_q + 32'd4;
  assign unused_stop_bits = ^stop_all[5:1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StReset;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      bus_error_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      count_q       <= 8'h0;
    end else begin
      unique case (state_q)
        StReset: state_q <= StReq;
        StReq: begin
          if (ibus_ack) begin
            // The in-flight word is the delay slot: always delivered, even on redirect.
            instr_q       <= ibus_data;
            instr_valid_q <= 1'b1;
            count_q       <= 8'h0;
            if (stop_fetch) begin
              // Pending redirect survives the stall and is applied on release.
              state_q <= StHold;
            end else begin
              pend_valid_q <= 1'b0;
              if (branch_take)       pc_q <= branch_address_input;
              else if (pend_valid_q) pc_q <= pend_target_q;
              else                   pc_q <= pc_inc;
            end
          end else begin
            instr_valid_q <= 1'b0;
            if (branch_take) begin
              pend_valid_q  <= 1'b1;
              pend_target_q <= branch_address_input;
            end
            if (count_q == CountLast) begin
              state_q     <= StErr;
              bus_error_q <= 1'b1;
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (!stop_fetch) begin
            state_q      <= StReq;
            pc_q         <= pend_valid_q ? pend_target_q : pc_inc;
            pend_valid_q <= 1'b0;
          end
        end
        StErr: bus_error_q <= 1'b1;
        default: state_q <= StReset;
      endcase
    end
  end

  always_comb begin
    ibus_request  = (state_q == StReq);
    stall_request = ((state_q == StReq) && !ibus_ack) || (state_q == StErr);
  end

  assign ibus_address      = pc_q;
  assign program_counter   = pc_q;
  assign instruction       = instr_q;
  assign instruction_valid = instr_valid_q;
  assign bus_error         = bus_error_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, timeout/reset sequences, then random stimulus
// against a transaction-level reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] K = 32'hA5A5_A5A5;
  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stop_all;
  logic        is_branch_input;
  logic [31:0] branch_address_input;
  logic        ibus_ack;
  logic [31:0] ibus_data;
  logic        ibus_request;
  logic [31:0] ibus_address;
  logic [31:0] program_counter;
  logic [31:0] instruction;
  logic        instruction_valid;
  logic        stall_request;
  logic        bus_error;

  logic [31:0] w_data, w_addr, w_pc, w_instr;
  logic        w_req, w_valid, w_stall, w_berr;

  always #5 clock = ~clock;

  assign ibus_data = ibus_address ^ K;
  assign w_data    = w_addr ^ K;

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .stop_all(stop_all), .is_branch_input(is_branch_input),
    .branch_address_input(branch_address_input), .ibus_ack(ibus_ack), .ibus_data(ibus_data),
    .ibus_request(ibus_request), .ibus_address(ibus_address),
    .program_counter(program_counter), .instruction(instruction),
    .instruction_valid(instruction_valid), .stall_request(stall_request),
    .bus_error(bus_error)
  );

  fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC), .TIMEOUT_CYCLES(TO)) dut_w (
    .clock(clock), .reset(reset), .stop_all(stop_all), .is_branch_input(is_branch_input),
    .branch_address_input(branch_address_input), .ibus_ack(ibus_ack), .ibus_data(w_data),
    .ibus_request(w_req), .ibus_address(w_addr), .program_counter(w_pc),
    .instruction(w_instr), .instruction_valid(w_valid), .stall_request(w_stall),
    .bus_error(w_berr)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        stop;
    logic        br;
    logic [31:0] ba;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic        stall;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[21];

  // Reference model: a fetch is "boot", "dead", "parked" or actively requesting.
  bit          m_known, m_boot, m_dead, m_parked, m_have;
  int          m_wait;
  logic [31:0] m_pc, m_word;
  logic [31:0] m_redir[$];

  task automatic model_check();
    logic exp_req;
    exp_req = !m_boot && !m_dead && !m_parked;
    chk("rnd_req", ibus_request, exp_req);
    chk("rnd_addr", ibus_address, m_pc);
    chk("rnd_pc", program_counter, m_pc);
    chk("rnd_stall", stall_request, m_dead || (exp_req && !ibus_ack));
    chk("rnd_valid", instruction_valid, m_have);
    chk("rnd_instr", instruction, m_word);
    chk("rnd_berr", bus_error, m_dead);
  endtask

  task automatic model_step();
    logic sampled;
    sampled = !stop_all[0] && is_branch_input;
    if (reset) begin
      m_known = 1; m_boot = 1; m_dead = 0; m_parked = 0; m_have = 0;
      m_wait = 0; m_pc = 32'h0; m_word = 32'h0; m_redir.delete();
    end else if (!m_known || m_dead) begin
      // nothing to track
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_parked) begin
      if (!stop_all[0]) begin
        m_pc = (m_redir.size() > 0) ? m_redir[$] : m_pc + 32'd4;
        m_redir.delete();
        m_parked = 0;
      end
    end else if (ibus_ack) begin
      m_word = m_pc ^ K;
      m_have = 1;
      m_wait = 0;
      if (stop_all[0]) m_parked = 1;
      else begin
        if (sampled)                  m_pc = branch_address_input;
        else if (m_redir.size() > 0)  m_pc = m_redir[$];
        else                          m_pc = m_pc + 32'd4;
        m_redir.delete();
      end
    end else begin
      m_have = 0;
      if (sampled) m_redir.push_back(branch_address_input);
      m_wait++;
      if (m_wait == TO) m_dead = 1;
    end
  endtask

  initial begin
    int mode;
    tbl[0]  = '{0, 0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0};
    tbl[1]  = '{0, 0, 32'h0,   1, 1, 32'h0,   0, 0, 32'h0};
    tbl[2]  = '{0, 0, 32'h0,   1, 1, 32'h4,   1, 0, K ^ 32'h0};
    tbl[3]  = '{0, 0, 32'h0,   1, 1, 32'h8,   1, 0, K ^ 32'h4};
    tbl[4]  = '{0, 0, 32'h0,   1, 1, 32'hC,   1, 0, K ^ 32'h8};
    tbl[5]  = '{0, 0, 32'h0,   0, 1, 32'h10,  1, 1, K ^ 32'hC};
    tbl[6]  = '{0, 1, 32'h100, 0, 1, 32'h10,  0, 1, K ^ 32'hC};
    tbl[7]  = '{0, 0, 32'h0,   0, 1, 32'h10,  0, 1, K ^ 32'hC};
    tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'h10,  0, 0, K ^ 32'hC};
    tbl[9]  = '{0, 0, 32'h0,   1, 1, 32'h100, 1, 0, K ^ 32'h10};
    tbl[10] = '{0, 0, 32'h0,   0, 1, 32'h104, 1, 1, K ^ 32'h100};
    tbl[11] = '{1, 0, 32'h0,   1, 1, 32'h104, 0, 0, K ^ 32'h100};
    tbl[12] = '{1, 0, 32'h0,   0, 0, 32'h104, 1, 0, K ^ 32'h104};
    tbl[13] = '{0, 0, 32'h0,   0, 0, 32'h104, 1, 0, K ^ 32'h104};
    tbl[14] = '{0, 1, 32'h40,  0, 1, 32'h108, 1, 1, K ^ 32'h104};
    tbl[15] = '{1, 0, 32'h0,   1, 1, 32'h108, 0, 0, K ^ 32'h104};
    tbl[16] = '{1, 1, 32'h999, 0, 0, 32'h108, 1, 0, K ^ 32'h108};
    tbl[17] = '{0, 0, 32'h0,   0, 0, 32'h108, 1, 0, K ^ 32'h108};
    tbl[18] = '{0, 1, 32'h200, 1, 1, 32'h40,  1, 0, K ^ 32'h108};
    tbl[19] = '{0, 0, 32'h0,   1, 1, 32'h200, 1, 0, K ^ 32'h40};
    tbl[20] = '{0, 0, 32'h0,   0, 1, 32'h204, 1, 1, K ^ 32'h200};

    reset = 1'b1; stop_all = 6'b0; is_branch_input = 1'b0;
    branch_address_input = 32'h0; ibus_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Directed table; other stop_all bits toggle to show only bit 0 matters.
    for (int i = 0; i < 21; i++) begin
      stop_all             = tbl[i].stop ? 6'b000011 : 6'b101010;
      is_branch_input      = tbl[i].br;
      branch_address_input = tbl[i].ba;
      ibus_ack             = tbl[i].ack;
      @(negedge clock);
      chk($sformatf("vec%0d_req", i), ibus_request, tbl[i].req);
      chk($sformatf("vec%0d_addr", i), ibus_address, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), instruction_valid, tbl[i].valid);
      chk($sformatf("vec%0d_stall", i), stall_request, tbl[i].stall);
      chk($sformatf("vec%0d_instr", i), instruction, tbl[i].ins);
      chk($sformatf("vec%0d_berr", i), bus_error, 1'b0);
      if (i == 1) chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      if (i == 2) chk("wrap_second_addr", w_addr, 32'h0);
      if (i == 3) chk("wrap_third_addr", w_addr, 32'h4);
      @(posedge clock); #1;
    end

    // Reset while a fetch is waiting on memory.
    stop_all = 6'b0; is_branch_input = 1'b0; ibus_ack = 1'b0; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midrst_req", ibus_request, 1'b0);
    chk("midrst_addr", ibus_address, 32'h0);
    chk("midrst_valid", instruction_valid, 1'b0);
    chk("midrst_stall", stall_request, 1'b0);
    chk("midrst_instr", instruction, 32'h0);
    chk("midrst_berr", bus_error, 1'b0);
    @(posedge clock); #1;

    // Timeout: 16 un-acked request cycles, then sticky error.
    for (int k = 0; k < int'(TO); k++) begin
      @(negedge clock);
      chk($sformatf("to_wait%0d_berr", k), bus_error, 1'b0);
      chk($sformatf("to_wait%0d_req", k), ibus_request, 1'b1);
      @(posedge clock); #1;
    end
    for (int k = 0; k < 4; k++) begin
      ibus_ack = (k > 0);
      @(negedge clock);
      chk($sformatf("to_err%0d_berr", k), bus_error, 1'b1);
      chk($sformatf("to_err%0d_req", k), ibus_request, 1'b0);
      chk($sformatf("to_err%0d_stall", k), stall_request, 1'b1);
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("to_rst_berr", bus_error, 1'b0);
    chk("to_rst_addr", ibus_address, 32'h0);
    @(posedge clock); #1;

    // Random stimulus against the reference model.
    m_known = 0;
    mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) mode = $urandom_range(0, 3);
      reset                = (c < 2) || ($urandom_range(0, 199) == 0) ||
                             ((c % 64 == 0) && ($urandom_range(0, 1) == 0));
      stop_all             = {5'($urandom), ($urandom_range(0, 3) == 0)};
      is_branch_input      = ($urandom_range(0, 5) == 0);
      branch_address_input = $urandom;
      if (mode == 3)      ibus_ack = 1'b0;
      else if (mode == 0) ibus_ack = ($urandom_range(0, 1) == 0);
      else                ibus_ack = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      if (m_known) model_check();
      model_step();
      @(posedge clock); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
